// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds the 10-bit symbol boundary by hunting for runs of
// control tokens at each bit offset, holds lock, and decodes symbols into
// data enable, 2-bit control and 8-bit pixel data.
module tmds_channel_decoder #(
  parameter int CTRL_RUN   = 16,
  parameter int SEARCH_WIN = 1024,
  parameter int LOCK_WIN   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WIN);
  localparam int LOCK_W = $clog2(LOCK_WIN);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WIN - 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [9:0]        din_prev_q;
  logic              de_q, de_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [7:0]        data_q, data_d;

  // Two consecutive words form a 20-bit window; the offset picks the symbol.
  logic [19:0] cat;
  logic [9:0]  sym;
  assign cat = {din, din_prev_q};
  assign sym = 10'(cat >> offset_q);

  // Token classification of the selected symbol.
  logic       is_ctrl;
  logic [1:0] tok;
  always_comb begin
    is_ctrl = 1'b1;
    tok     = 2'b00;
    case (sym)
      10'h354: tok = 2'b00;
      10'h0AB: tok = 2'b01;
      10'h154: tok = 2'b10;
      10'h2AB: tok = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  // Data decode: undo optional inversion, then undo the XOR/XNOR chain.
  logic [7:0] d_inv;
  logic [7:0] dec;
  assign d_inv  = sym[9] ? ~sym[7:0] : sym[7:0];
  assign dec[0] = d_inv[0];
  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign dec[gi] = sym[8] ? (d_inv[gi] ^ d_inv[gi-1]) : ~(d_inv[gi] ^ d_inv[gi-1]);
  end

  logic             run_hit;
  logic [RUN_W-1:0] run_step;
  assign run_hit  = (run_q == RUN_MAX);
  assign run_step = !is_ctrl ? '0 : (run_hit ? run_q : run_q + RUN_W'(1));

  // State, counter and output registers; async assert, clocked release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SEARCH;
      offset_q   <= 4'd0;
      run_q      <= '0;
      win_q      <= '0;
      lock_q     <= '0;
      din_prev_q <= 10'd0;
      de_q       <= 1'b0;
      ctrl_q     <= 2'b00;
      data_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      run_q      <= run_d;
      win_q      <= win_d;
      lock_q     <= lock_d;
      din_prev_q <= din;
      de_q       <= de_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
    end
  end

  // Alignment FSM next state plus decoded output next values.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    win_d    = win_q;
    lock_d   = lock_q;
    de_d     = 1'b0;
    ctrl_d   = 2'b00;
    data_d   = 8'd0;

    case (state_q)
      ST_SEARCH: begin
        win_d = win_q + WIN_W'(1);
        run_d = run_step;
        if (run_hit) begin
          // A full run beats a window expiring on the same cycle.
          state_d = ST_LOCKED;
          lock_d  = '0;
          win_d   = '0;
          run_d   = '0;
        end else if (win_q == WIN_LAST) begin
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          win_d    = '0;
          run_d    = '0;
        end
      end
      ST_LOCKED: begin
        lock_d = lock_q + LOCK_W'(1);
        run_d  = run_step;
        if (run_hit) begin
          // Fresh run refreshes the lock; a new run is needed for the next refresh.
          lock_d = '0;
          run_d  = '0;
        end else if (lock_q == LOCK_LAST) begin
          state_d = ST_SEARCH;
          win_d   = '0;
          run_d   = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    // Outputs follow the state being entered so they are zero whenever locked is low.
    if (state_d == ST_LOCKED) begin
      if (is_ctrl) begin
        ctrl_d = tok;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
      end
    end
  end

  assign de     = de_q;
  assign ctrl   = ctrl_q;
  assign data   = data_q;
  assign locked = (state_q == ST_LOCKED);
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: the stimulus side pushes expected
// decoded bytes, a negedge monitor pops and compares on every data output.
module tb_tmds_channel_decoder;

  localparam int CR = 4;
  localparam int SW = 32;
  localparam int LW = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = 10'h354;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       locked;
  logic [3:0] offset;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .CTRL_RUN  (CR),
    .SEARCH_WIN(SW),
    .LOCK_WIN  (LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .de    (de),
    .ctrl  (ctrl),
    .data  (data),
    .locked(locked),
    .offset(offset)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         data_chk_en = 1'b0;
  bit         ctrl_chk_en = 1'b0;
  logic [1:0] ctrl_exp = 2'b00;
  logic [9:0] cur_sym = 10'h354;
  int         skew = 0;

  // Hand-decoded data symbols.
  logic [9:0] dsym[6] = '{10'h100, 10'h200, 10'h1FF, 10'h0F0, 10'h2F0, 10'h155};
  logic [7:0] dexp[6] = '{8'h00,   8'hFF,   8'h01,   8'hEE,   8'hEF,   8'hFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one symbol of the serial stream, cut into words 'skew' bits late.
  task automatic send_sym(input logic [9:0] s, input bit push, input logic [7:0] exp_b);
    logic [19:0] pair;
    @(posedge clk);
    #1;
    pair    = {s, cur_sym};
    din     = (skew == 0) ? s : 10'(pair >> skew);
    cur_sym = s;
    if (push) exp_q.push_back(exp_b);
  endtask

  // 0x354 blanking with one data symbol every eighth slot.
  task automatic send_pattern(input int i, input bit push);
    if (i % 8 == 7) send_sym(dsym[(i / 8) % 6], push, dexp[(i / 8) % 6]);
    else            send_sym(10'h354, 1'b0, 8'h00);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: one comparison per output cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!locked) begin
        chk("idle_outputs", {21'd0, de, ctrl, data}, 32'd0);
      end else if (de) begin
        if (data_chk_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_data actual=%0h required=<no pending byte>", data);
          end else begin
            chk("sb_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
          end
        end
      end else if (ctrl_chk_en) begin
        chk("sb_ctrl", {22'd0, ctrl, data}, {22'd0, ctrl_exp, 8'h00});
      end
      if (offset > 4'd9) chk("offset_range", {28'd0, offset}, 32'd9);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  lock_e;
    int  n;
    bit  saw_de;

    // Reset state.
    #12;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_offset", {28'd0, offset}, 32'd0);
    chk("rst_outputs", {21'd0, de, ctrl, data}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Aligned 0x354 stream locks after about CTRL_RUN cycles.
    lock_e = -1;
    for (int e = 1; e <= CR + 10; e++) begin
      send_sym(10'h354, 1'b0, 8'h00);
      if (locked && lock_e < 0) lock_e = e;
    end
    chk("t1_lock_edge_in_range", {31'd0, (lock_e >= CR + 1 && lock_e <= CR + 3)}, 32'd1);
    chk("t1_offset", {28'd0, offset}, 32'd0);
    chk("t1_ctrl", {21'd0, de, ctrl, data}, 32'd0);
    ctrl_exp    = 2'b00;
    ctrl_chk_en = 1'b1;

    // Data lines between 0x0AB blanking.
    ctrl_chk_en = 1'b0;
    repeat (6) send_sym(10'h0AB, 1'b0, 8'h00);
    ctrl_exp    = 2'b01;
    ctrl_chk_en = 1'b1;
    data_chk_en = 1'b1;
    for (int line = 0; line < 3; line++) begin
      for (int j = 0; j < 6; j++) send_sym(dsym[j], 1'b1, dexp[j]);
      for (int j = 0; j < 4; j++) begin
        send_sym(10'h100, 1'b1, 8'h00);
        send_sym(10'h200, 1'b1, 8'hFF);
      end
      repeat (8) send_sym(10'h0AB, 1'b0, 8'h00);
    end

    // Two-cycle latency of a single data word.
    send_sym(10'h200, 1'b1, 8'hFF);
    @(negedge clk);
    chk("lat_edge0_de", {31'd0, de}, 32'd0);
    send_sym(10'h0AB, 1'b0, 8'h00);
    @(negedge clk);
    chk("lat_edge1_de", {31'd0, de}, 32'd0);
    send_sym(10'h0AB, 1'b0, 8'h00);
    @(negedge clk);
    chk("lat_edge2_de", {31'd0, de}, 32'd1);
    chk("lat_edge2_data", {24'd0, data}, 32'h0FF);
    repeat (8) send_sym(10'h0AB, 1'b0, 8'h00);
    chk("t2_queue_empty", exp_q.size(), 32'd0);
    chk("t2_still_locked", {31'd0, locked}, 32'd1);

    // Stream with boundary skewed: offset walks 0,1,2,3 then locks at 3.
    data_chk_en = 1'b0;
    ctrl_chk_en = 1'b0;
    skew = 7;
    reset_dut();
    for (int e = 1; e <= 3 * SW; e++) begin
      send_pattern(e, 1'b0);
      if (e == SW - 1) chk("t5_offset_before_step", {28'd0, offset}, 32'd0);
      if (e == SW)     chk("t5_offset_step1", {28'd0, offset}, 32'd1);
      if (e == 2 * SW) chk("t5_offset_step2", {28'd0, offset}, 32'd2);
      if (e == 3 * SW) chk("t5_offset_step3", {28'd0, offset}, 32'd3);
    end
    for (int e = 0; e < SW && !locked; e++) send_pattern(e, 1'b0);
    chk("t5_locked", {31'd0, locked}, 32'd1);
    chk("t5_offset", {28'd0, offset}, 32'd3);
    repeat (8) send_sym(10'h354, 1'b0, 8'h00);
    ctrl_exp    = 2'b00;
    ctrl_chk_en = 1'b1;
    data_chk_en = 1'b1;
    for (int i = 0; i < 48; i++) send_pattern(i, 1'b1);
    repeat (8) send_sym(10'h354, 1'b0, 8'h00);
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset mid-line while data is on the outputs.
    saw_de = 1'b0;
    for (int k = 0; k < 8 && !saw_de; k++) begin
      send_sym(10'h2F0, 1'b1, 8'hEF);
      if (de) saw_de = 1'b1;
    end
    chk("t3_saw_data", {31'd0, saw_de}, 32'd1);
    #1;
    rst_n       = 1'b0;
    data_chk_en = 1'b0;
    ctrl_chk_en = 1'b0;
    exp_q.delete();
    #1;
    chk("t3_async_locked", {31'd0, locked}, 32'd0);
    chk("t3_async_offset", {28'd0, offset}, 32'd0);
    chk("t3_async_outputs", {21'd0, de, ctrl, data}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 4 * SW + 20 && !locked; e++) send_pattern(e, 1'b0);
    chk("t3_relocked", {31'd0, locked}, 32'd1);
    chk("t3_relock_offset", {28'd0, offset}, 32'd3);

    // Data-only words: lock times out, outputs forced, offset kept.
    repeat (8) send_sym(10'h354, 1'b0, 8'h00);
    n = 0;
    for (int k = 0; k < LW + 20; k++) begin
      send_sym(10'h100, 1'b0, 8'h00);
      n++;
      if (!locked) break;
    end
    chk("t4_timeout_in_range", {31'd0, (n >= LW - CR - 2 && n <= LW + 4)}, 32'd1);
    chk("t4_locked", {31'd0, locked}, 32'd0);
    chk("t4_offset_kept", {28'd0, offset}, 32'd3);
    chk("t4_outputs_forced", {21'd0, de, ctrl, data}, 32'd0);

    // No tokens: offset walks up to 9 and wraps to 0 without locking.
    skew = 0;
    reset_dut();
    for (int e = 1; e <= 10 * SW; e++) begin
      send_sym(10'h000, 1'b0, 8'h00);
      if (e == 9 * SW - 1) chk("t6_offset8", {28'd0, offset}, 32'd8);
      if (e == 9 * SW)     chk("t6_offset9", {28'd0, offset}, 32'd9);
      if (e == 10 * SW)    chk("t6_offset_wrap", {28'd0, offset}, 32'd0);
    end
    chk("t6_not_locked", {31'd0, locked}, 32'd0);
    chk("t6_outputs", {21'd0, de, ctrl, data}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
